// File: rtl/disp_pkg.sv
// Shared display constants for the VGA pixel path: colour width, raster defaults,
// ROM address width and glyph indices.
package disp_pkg;

    localparam int RGB_W      = 12;
    localparam int HV_W       = 11;
    localparam int ADDR_W     = 19;
    localparam int DISP_H_ACT = 640;
    localparam int DISP_V_ACT = 480;

    typedef enum logic [3:0] {
        GLYPH_ZERO   = 4'd0,
        GLYPH_ONE    = 4'd1,
        GLYPH_TWO    = 4'd2,
        GLYPH_THREE  = 4'd3,
        GLYPH_FOUR   = 4'd4,
        GLYPH_FIVE   = 4'd5,
        GLYPH_SIX    = 4'd6,
        GLYPH_SEVEN  = 4'd7,
        GLYPH_EIGHT  = 4'd8,
        GLYPH_NINE   = 4'd9,
        GLYPH_TEN    = 4'd10,
        GLYPH_ELEVEN = 4'd11
    } glyph_e;

    localparam int GLYPH_MAX = int'(GLYPH_ELEVEN);

endpackage

// File: rtl/tile_locate.sv
// One-axis tile locator: finds which tile span a coordinate falls in and the offset
// inside it. Span bounds are elaboration constants, so this is a comparator chain only.
module tile_locate #(
    parameter int N      = 4,
    parameter int TILE_W = 80,
    parameter int PITCH  = 96,
    parameter int ORG    = 136,
    parameter int IDX_W  = 2,
    parameter int OFS_W  = 7
) (
    input  logic [10:0]      i_pos,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_hit,
    output logic [OFS_W-1:0] o_ofs
);

    logic [31:0] w_pos;
    assign w_pos = 32'(i_pos);

    always_comb begin
        o_idx = '0;
        o_hit = 1'b0;
        o_ofs = '0;
        for (int c = 0; c < N; c++) begin
            if (w_pos >= 32'(ORG + c * PITCH) && w_pos < 32'(ORG + c * PITCH + TILE_W)) begin
                o_idx = IDX_W'(c);
                o_hit = 1'b1;
                o_ofs = OFS_W'(w_pos - 32'(ORG + c * PITCH));
            end
        end
    end

endmodule

// File: rtl/tile_pixel_pipe.sv
// Pipelined board renderer: locates the tile under (h,v), drives glyph/background ROM
// addresses, aligns side-band to ROM latency and blinks a freshly spawned tile.
module tile_pixel_pipe
    import disp_pkg::*;
#(
    parameter int GRID_N       = 4,
    parameter int TILE_W       = 80,
    parameter int PITCH        = 96,
    parameter int ORG_X        = 136,
    parameter int ORG_Y        = 66,
    parameter int H_ACT        = DISP_H_ACT,
    parameter int VAL_W        = 4,
    parameter int MAX_VAL      = GLYPH_MAX,
    parameter int ROM_LAT      = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [HV_W-1:0]                   i_h_cnt,
    input  logic [HV_W-1:0]                   i_v_cnt,
    input  logic                              i_act,
    input  logic                              i_frame_start,
    input  logic [GRID_N*GRID_N*VAL_W-1:0]    i_board,
    input  logic                              i_spawn_stb,
    input  logic [$clog2(GRID_N*GRID_N)-1:0]  i_spawn_pos,
    output logic [ADDR_W-1:0]                 o_bg_addr,
    output logic [$clog2(TILE_W*TILE_W)-1:0]  o_tile_addr,
    output logic [VAL_W-1:0]                  o_tile_sel,
    input  logic [RGB_W-1:0]                  i_tile_pix,
    input  logic [RGB_W-1:0]                  i_bg_pix,
    output logic [RGB_W-1:0]                  o_pixel,
    output logic                              o_pixel_vld
);

    localparam int CELLS = GRID_N * GRID_N;
    localparam int POS_W = $clog2(CELLS);
    localparam int IDX_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
    localparam int OFS_W = $clog2(TILE_W);
    localparam int TA_W  = $clog2(TILE_W * TILE_W);
    localparam int FC_W  = $clog2(FLASH_FRAMES + 1);

    logic [CELLS*VAL_W-1:0] r_shadow;
    logic [FC_W-1:0]        r_flash_cnt;
    logic [POS_W-1:0]       r_spawn_reg;

    logic                   r_s1_act, r_s1_in_tile;
    logic [HV_W-1:0]        r_s1_h, r_s1_v;
    logic [IDX_W-1:0]       r_s1_col, r_s1_row;
    logic [OFS_W-1:0]       r_s1_lx, r_s1_ly;

    logic                   r_s2_act, r_s2_use;
    logic [ADDR_W-1:0]      r_bg_addr;
    logic [TA_W-1:0]        r_tile_addr;
    logic [VAL_W-1:0]       r_tile_sel;

    logic [ROM_LAT-1:0]     r_use_d, r_act_d;
    logic [RGB_W-1:0]       r_pixel;
    logic                   r_pixel_vld;

    logic [IDX_W-1:0]       w_col, w_row;
    logic                   w_hit_x, w_hit_y;
    logic [OFS_W-1:0]       w_lx, w_ly;

    tile_locate #(.N(GRID_N), .TILE_W(TILE_W), .PITCH(PITCH), .ORG(ORG_X),
                  .IDX_W(IDX_W), .OFS_W(OFS_W)) u_loc_x (
        .i_pos(i_h_cnt), .o_idx(w_col), .o_hit(w_hit_x), .o_ofs(w_lx));

    tile_locate #(.N(GRID_N), .TILE_W(TILE_W), .PITCH(PITCH), .ORG(ORG_Y),
                  .IDX_W(IDX_W), .OFS_W(OFS_W)) u_loc_y (
        .i_pos(i_v_cnt), .o_idx(w_row), .o_hit(w_hit_y), .o_ofs(w_ly));

    logic [POS_W-1:0]  w_cell;
    logic [VAL_W-1:0]  w_val;
    logic              w_hide, w_use;
    logic [TA_W-1:0]   w_tile_addr;
    logic [VAL_W-1:0]  w_tile_sel;
    logic [ADDR_W-1:0] w_bg_addr;

    assign w_cell      = POS_W'(32'(r_s1_row) * GRID_N + 32'(r_s1_col));
    assign w_val       = r_shadow[32'(w_cell) * VAL_W +: VAL_W];
    // Blink phase: hidden while flash_cnt bit 1 is set (e.g. 7,6,3,2 for an 8-frame blink).
    assign w_hide      = r_s1_in_tile && (r_flash_cnt != '0) && (w_cell == r_spawn_reg)
                         && r_flash_cnt[1];
    assign w_use       = r_s1_in_tile && (w_val != VAL_W'(GLYPH_ZERO)) && !w_hide;
    assign w_tile_addr = TA_W'(32'(r_s1_ly) * TILE_W + 32'(r_s1_lx));
    assign w_tile_sel  = (w_val > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : w_val;
    assign w_bg_addr   = ADDR_W'(32'(r_s1_v) * H_ACT + 32'(r_s1_h));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow     <= '0;
            r_flash_cnt  <= '0;
            r_spawn_reg  <= '0;
            r_s1_act     <= 1'b0;
            r_s1_in_tile <= 1'b0;
            r_s1_h       <= '0;
            r_s1_v       <= '0;
            r_s1_col     <= '0;
            r_s1_row     <= '0;
            r_s1_lx      <= '0;
            r_s1_ly      <= '0;
            r_s2_act     <= 1'b0;
            r_s2_use     <= 1'b0;
            r_bg_addr    <= '0;
            r_tile_addr  <= '0;
            r_tile_sel   <= '0;
            r_use_d      <= '0;
            r_act_d      <= '0;
            r_pixel      <= '0;
            r_pixel_vld  <= 1'b0;
        end else begin
            if (i_frame_start)
                r_shadow <= i_board;

            // A spawn on the frame_start cycle reloads the full count with no decrement.
            if (i_spawn_stb) begin
                r_spawn_reg <= i_spawn_pos;
                r_flash_cnt <= FC_W'(FLASH_FRAMES);
            end else if (i_frame_start && r_flash_cnt != '0) begin
                r_flash_cnt <= r_flash_cnt - 1'b1;
            end

            r_s1_act     <= i_act;
            r_s1_in_tile <= w_hit_x && w_hit_y;
            r_s1_h       <= i_h_cnt;
            r_s1_v       <= i_v_cnt;
            r_s1_col     <= w_col;
            r_s1_row     <= w_row;
            r_s1_lx      <= w_lx;
            r_s1_ly      <= w_ly;

            r_s2_act  <= r_s1_act;
            r_s2_use  <= w_use;
            r_bg_addr <= w_bg_addr;
            if (r_s1_in_tile) begin
                r_tile_addr <= w_tile_addr;
                r_tile_sel  <= w_tile_sel;
            end else begin
                r_tile_addr <= '0;
                r_tile_sel  <= '0;
            end

            r_use_d[0] <= r_s2_use;
            r_act_d[0] <= r_s2_act;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_use_d[i] <= r_use_d[i-1];
                r_act_d[i] <= r_act_d[i-1];
            end

            r_pixel     <= !r_act_d[ROM_LAT-1] ? '0 :
                           r_use_d[ROM_LAT-1]  ? i_tile_pix : i_bg_pix;
            r_pixel_vld <= r_act_d[ROM_LAT-1];
        end
    end

    assign o_bg_addr   = r_bg_addr;
    assign o_tile_addr = r_tile_addr;
    assign o_tile_sel  = r_tile_sel;
    assign o_pixel     = r_pixel;
    assign o_pixel_vld = r_pixel_vld;

endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Bench for tile_pixel_pipe: ROM_LAT=1 and ROM_LAT=2 instances share stimulus and are
// checked against a geometric reference model of the board renderer.
module tb_tile_pixel_pipe;

    localparam int LAT1 = 4;
    localparam int LAT2 = 5;

    typedef struct packed {
        logic [11:0] pix;
        logic        vld;
        logic [18:0] bg;
        logic [12:0] ta;
        logic [3:0]  ts;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] h = '0, v = '0;
    logic        act = 1'b0, fs = 1'b0, sp_stb = 1'b0;
    logic [63:0] board = '0;
    logic [3:0]  sp_pos = '0;

    logic [18:0] bg1, bg2;
    logic [12:0] ta1, ta2;
    logic [3:0]  ts1, ts2;
    logic [11:0] pix1, pix2, tp1, bp1, tp2, bp2, tp2a, bp2a;
    logic        vld1, vld2;

    int   checks = 0;
    int   errors = 0;
    ent_t hist[0:7];
    int   m_shadow[16];
    int   m_flash = 0;
    int   m_spawn = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] trom(input logic [3:0] s, input logic [12:0] a);
        return {s, a[7:0]} ^ {3'b101, a[12:4]};
    endfunction

    function automatic logic [11:0] brom(input logic [18:0] a);
        return a[11:0] ^ {5'b01100, a[18:12]};
    endfunction

    always @(posedge clk) begin
        tp1  <= trom(ts1, ta1);
        bp1  <= brom(bg1);
        tp2a <= trom(ts2, ta2);
        bp2a <= brom(bg2);
        tp2  <= tp2a;
        bp2  <= bp2a;
    end

    tile_pixel_pipe #(.ROM_LAT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_h_cnt(h), .i_v_cnt(v), .i_act(act),
        .i_frame_start(fs), .i_board(board), .i_spawn_stb(sp_stb), .i_spawn_pos(sp_pos),
        .o_bg_addr(bg1), .o_tile_addr(ta1), .o_tile_sel(ts1),
        .i_tile_pix(tp1), .i_bg_pix(bp1), .o_pixel(pix1), .o_pixel_vld(vld1));

    tile_pixel_pipe #(.ROM_LAT(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_h_cnt(h), .i_v_cnt(v), .i_act(act),
        .i_frame_start(fs), .i_board(board), .i_spawn_stb(sp_stb), .i_spawn_pos(sp_pos),
        .o_bg_addr(bg2), .o_tile_addr(ta2), .o_tile_sel(ts2),
        .i_tile_pix(tp2), .i_bg_pix(bp2), .o_pixel(pix2), .o_pixel_vld(vld2));

    // Reference: tile geometry by division/remainder over the raster.
    function automatic ent_t model(input int hh, input int vv, input bit a);
        ent_t e;
        int   dx, dy, c, r, lx, ly, idx, val;
        bit   in_t, hide, use_t;
        e = '0;
        e.bg = 19'(vv * 640 + hh);
        in_t = 1'b0;
        use_t = 1'b0;
        if (hh >= 136 && vv >= 66) begin
            dx = hh - 136; dy = vv - 66;
            c = dx / 96; r = dy / 96; lx = dx % 96; ly = dy % 96;
            in_t = (c < 4) && (r < 4) && (lx < 80) && (ly < 80);
            if (in_t) begin
                idx  = r * 4 + c;
                val  = m_shadow[idx];
                hide = (m_flash != 0) && (idx == m_spawn) && m_flash[1];
                use_t = (val != 0) && !hide;
                e.ta = 13'(ly * 80 + lx);
                e.ts = 4'((val > 11) ? 11 : val);
            end
        end
        e.vld = a;
        e.pix = !a ? 12'h000 : use_t ? trom(e.ts, e.ta) : brom(e.bg);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pixel_lat1", 32'(pix1), 32'(hist[LAT1-1].pix));
        chk("vld_lat1",   32'(vld1), 32'(hist[LAT1-1].vld));
        chk("pixel_lat2", 32'(pix2), 32'(hist[LAT2-1].pix));
        chk("vld_lat2",   32'(vld2), 32'(hist[LAT2-1].vld));
        chk("tile_addr",  32'(ta1),  32'(hist[1].ta));
        chk("tile_sel",   32'(ts1),  32'(hist[1].ts));
        chk("bg_addr",    32'(bg1),  32'(hist[1].bg));
        chk("tile_addr2", 32'(ta2),  32'(hist[1].ta));
        chk("tile_sel2",  32'(ts2),  32'(hist[1].ts));
        chk("bg_addr2",   32'(bg2),  32'(hist[1].bg));
    endtask

    task automatic step(input int hh, input int vv, input bit a,
                        input bit f = 1'b0, input bit s = 1'b0, input int sp = 0);
        ent_t e;
        h = 11'(hh); v = 11'(vv); act = a; fs = f; sp_stb = s; sp_pos = 4'(sp);
        if (f)
            for (int k = 0; k < 16; k++) m_shadow[k] = int'(board[k*4 +: 4]);
        if (s) begin
            m_spawn = sp;
            m_flash = 8;
        end else if (f && m_flash != 0) begin
            m_flash--;
        end
        e = model(hh, vv, a);
        @(posedge clk);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = e;
        #1;
        fs = 1'b0; sp_stb = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) hist[i] = '0;
        for (int k = 0; k < 16; k++) m_shadow[k] = 0;
        m_flash = 0;
        m_spawn = 0;
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '0;
        #1;
        check_all();
    endtask

    task automatic set_cell(input int k, input int val);
        board[k*4 +: 4] = 4'(val);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) reset_cycle();
        rst_n = 1'b1;
        step(0, 0, 0);

        // Single glyph in cell 0, sampled at its (4,4) offset.
        set_cell(0, 1);
        step(0, 0, 0, 1'b1);
        step(140, 70, 1);
        step(330, 170, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        set_cell(6, 5);
        step(0, 0, 0, 1'b1);
        step(330, 170, 1);
        step(220, 70, 1);
        step(215, 145, 1);
        step(700, 470, 0);
        step(2000, 1500, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // Clamp and empty cell.
        set_cell(0, 15);
        step(0, 0, 0, 1'b1);
        step(140, 70, 1);
        step(215, 145, 1);
        set_cell(0, 0);
        step(0, 0, 0, 1'b1);
        step(140, 70, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // Board edits without frame_start must not reach the screen.
        set_cell(0, 3);
        step(140, 70, 1);
        step(141, 71, 1);
        step(0, 0, 0, 1'b1);
        step(140, 70, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // Spawn blink on cell 0 across ten frames.
        set_cell(0, 2);
        step(0, 0, 0, 1'b1);
        step(0, 0, 0, 1'b0, 1'b1, 0);
        step(140, 70, 1);
        for (int f = 0; f < 10; f++) begin
            step(0, 0, 0, 1'b1);
            step(140, 70, 1);
            step(200, 130, 1);
            step(330, 170, 1);
        end
        // Coincident spawn and frame_start: full count, so glyph visible, then hidden.
        step(0, 0, 0, 1'b1, 1'b1, 0);
        step(140, 70, 1);
        step(0, 0, 0, 1'b1);
        step(140, 70, 1);
        // Respawn on a different cell mid-blink.
        step(0, 0, 0, 1'b0, 1'b1, 6);
        step(140, 70, 1);
        step(0, 0, 0, 1'b1);
        step(330, 170, 1);
        step(140, 70, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // Randomised raster with sporadic frames, board changes and spawns.
        for (int i = 0; i < 400; i++) begin
            bit f, s;
            int hh, vv;
            f = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) begin
                hh = $urandom_range(641, 2047);
                vv = $urandom_range(0, 2047);
                step(hh, vv, 0, f, s, $urandom_range(0, 15));
            end else begin
                if (f) board = {$urandom(), $urandom()};
                hh = $urandom_range(100, 560);
                vv = $urandom_range(40, 460);
                step(hh, vv, ($urandom_range(0, 3) != 0), f, s, $urandom_range(0, 15));
            end
        end

        // Mid-line asynchronous reset.
        set_cell(0, 4);
        step(0, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) step(140 + i, 70, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pixel1", 32'(pix1), 32'h0);
        chk("rst_vld1",   32'(vld1), 32'h0);
        chk("rst_pixel2", 32'(pix2), 32'h0);
        chk("rst_vld2",   32'(vld2), 32'h0);
        model_reset();
        reset_cycle();
        reset_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(140 + i, 70, 1);
        step(0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(140 + i, 70, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
